sfsm_act: RTL and testbench
===========================

SFSM_ACT -- requirements
Module: sfsm_act

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of independent stochastic channels.
REQ-002 The block SHALL have parameter S, default 32, giving states per channel FSM; legal values are even and >= 4.
REQ-003 The block SHALL have parameter LGS, default 5, giving the state register width; LGS = ceil(log2(S)).
REQ-004 The block SHALL have parameter G, default 2, giving the exp-mode threshold offset; legal values are 1 to S-1.
REQ-005 The block SHALL have parameter INIT, default S/2, giving the per-channel state loaded at reset; legal values are 0 to S-1.
REQ-006 clk  input  1  The single clock; all state changes occur on its rising edge.
REQ-007 rst  input  1  Reset, synchronous and active-low.
REQ-008 en  input  1  Update enable; when low, all state and outputs hold.
REQ-009 mode  input  1  Activation select: 0 selects tanh and 1 selects exp; one mode is shared by all channels.
REQ-010 x  input  N  Stochastic bitstream inputs, one bit per channel.
REQ-011 y  output  N  Registered stochastic outputs, one bit per channel.

Function
REQ-012 Each channel SHALL hold an LGS-bit saturating up/down state st[i] in the range 0..S-1.
REQ-013 On a rising edge with rst high and en high, st[i] SHALL increment when x[i]=1 and st[i]<S-1; it SHALL decrement when x[i]=0 and st[i]>0; otherwise it SHALL hold.
REQ-014 Saturation SHALL be strict: no wrap past S-1 or below 0, under any input sequence.
REQ-015 On the same edge, y[i] SHALL be updated from the next-state value (latency 1 cycle from x to y).
REQ-016 Tanh decode (mode=0): y[i] SHALL be 1 if and only if next st[i] >= S/2.
REQ-017 Exp decode (mode=1): y[i] SHALL be 1 if and only if next st[i] < S-G.
REQ-018 A change of mode SHALL NOT alter st[i]; the new decode SHALL apply from the first enabled edge after the change.
REQ-019 When en is low, st[i] and y[i] SHALL hold and x and mode SHALL be ignored.
REQ-020 Channels SHALL be fully independent; no state, carry or decode term SHALL be shared between them except mode, en and rst.

Reset
REQ-021 On a rising edge with rst low, every st[i] SHALL load INIT and every y[i] SHALL load 0, regardless of en, x and mode.
REQ-022 Reset SHALL take priority over any update in the same cycle, including mid-stream; the first enabled edge after rst returns high SHALL update from INIT.
REQ-023 No asynchronous path SHALL exist from rst to any register.

Configuration
REQ-024 When macro SFSM_ACT_SAT_EN is defined, the block SHALL add output ports sat_hi[N-1:0] and sat_lo[N-1:0].
REQ-025 With SFSM_ACT_SAT_EN defined, sat_hi[i] and sat_lo[i] SHALL be registered and SHALL equal (next st[i]==S-1) and (next st[i]==0) respectively.
REQ-026 With SFSM_ACT_SAT_EN defined, sat_hi and sat_lo SHALL reset to 0 and SHALL hold when en is low.
REQ-027 When SFSM_ACT_SAT_EN is undefined, the ports and their logic SHALL be absent, and y behaviour SHALL be identical.

Verification (N=4, S=32, G=2, INIT=16)
REQ-028 Reset: rst=0 for 1 edge during traffic -> all st=16, y=4'b0000; sat_hi=sat_lo=0 with SFSM_ACT_SAT_EN defined.
REQ-029 Tanh up-saturate: mode=0, x[0]=1 for 20 edges -> st[0]=17..31 then held at 31, y[0]=1 from edge 1; with SFSM_ACT_SAT_EN defined, sat_hi[0]=1 from edge 15 on.
REQ-030 Tanh down-saturate: x[1]=0 for 20 edges -> st[1]=15 and y[1]=0 at edge 1, st[1]=0 at edge 16 and held; with SFSM_ACT_SAT_EN defined, sat_lo[1]=1 from edge 16; other lanes are unaffected.
REQ-031 Exp threshold: mode=1, x[2]=1 from st=16 -> y[2]=1 for edges 1-13 (st 17..29) and y[2]=0 from edge 14 (st=30).
REQ-032 Enable and mode switch: en=0 for 5 edges with random x -> st and y frozen; then mode 0->1 with st[3]=29 and x[3]=1 -> y[3]=0 (st=30).
REQ-033 Alternating input: mode=0, x[0]=1,0,1,0 from st=16 -> st=17,16,17,16 and y[0]=1,1,1,1.

Source files
------------

// File: rtl/sfsm_act_if.sv
// Channel bus for sfsm_act: enable, shared mode, per-channel bitstreams in/out.
// Saturation flags appear only when SFSM_ACT_SAT_EN is defined.
interface sfsm_act_if #(
  parameter int N = 4
) ();
  logic         en;
  logic         mode;
  logic [N-1:0] x;
  logic [N-1:0] y;
`ifdef SFSM_ACT_SAT_EN
  logic [N-1:0] sat_hi;
  logic [N-1:0] sat_lo;

  modport master (output en, mode, x, input  y, sat_hi, sat_lo);
  modport slave  (input  en, mode, x, output y, sat_hi, sat_lo);
`else
  modport master (output en, mode, x, input  y);
  modport slave  (input  en, mode, x, output y);
`endif
endinterface

// File: rtl/sfsm_act.sv
// Stochastic FSM activation: N independent saturating counters with tanh/exp decode.
// Optional macro SFSM_ACT_SAT_EN adds registered sat_hi/sat_lo flags per channel.
module sfsm_act_lane #(
  parameter int S    = 32,
  parameter int LGS  = 5,
  parameter int G    = 2,
  parameter int INIT = S/2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic mode,
  input  logic x,
`ifdef SFSM_ACT_SAT_EN
  output logic sat_hi,
  output logic sat_lo,
`endif
  output logic y
);
  localparam logic [LGS-1:0] ST_MAX  = LGS'(S-1);
  localparam logic [LGS-1:0] ST_MID  = LGS'(S/2);
  localparam logic [LGS-1:0] ST_EXP  = LGS'(S-G);
  localparam logic [LGS-1:0] ST_INIT = LGS'(INIT);

  logic [LGS-1:0] st, st_nxt;
  logic           y_nxt;

  always_comb begin
    st_nxt = st;
    if (x && st != ST_MAX)       st_nxt = st + 1'b1;
    else if (!x && st != '0)     st_nxt = st - 1'b1;
    // decode looks at the value being written, so y lags x by exactly one edge
    y_nxt = mode ? (st_nxt < ST_EXP) : (st_nxt >= ST_MID);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st <= ST_INIT;
      y  <= 1'b0;
    end else if (en) begin
      st <= st_nxt;
      y  <= y_nxt;
    end
  end

`ifdef SFSM_ACT_SAT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      sat_hi <= 1'b0;
      sat_lo <= 1'b0;
    end else if (en) begin
      sat_hi <= (st_nxt == ST_MAX);
      sat_lo <= (st_nxt == '0);
    end
  end
`endif
endmodule

module sfsm_act #(
  parameter int N    = 4,
  parameter int S    = 32,
  parameter int LGS  = 5,
  parameter int G    = 2,
  parameter int INIT = S/2
) (
  input  logic         clk,
  input  logic         rst,
  sfsm_act_if.slave    bus
);
  logic [N-1:0] y;
`ifdef SFSM_ACT_SAT_EN
  logic [N-1:0] sat_hi, sat_lo;
  assign bus.sat_hi = sat_hi;
  assign bus.sat_lo = sat_lo;
`endif
  assign bus.y = y;

  for (genvar i = 0; i < N; i++) begin : g_lane
    sfsm_act_lane #(.S(S), .LGS(LGS), .G(G), .INIT(INIT)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .en     (bus.en),
      .mode   (bus.mode),
      .x      (bus.x[i]),
`ifdef SFSM_ACT_SAT_EN
      .sat_hi (sat_hi[i]),
      .sat_lo (sat_lo[i]),
`endif
      .y      (y[i])
    );
  end
endmodule

// File: tb/tb_sfsm_act.sv
// Bench for sfsm_act: directed scenarios plus random traffic against a counter-array model.
module tb_sfsm_act;
  localparam int N = 4, S = 32, LGS = 5, G = 2, INIT = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sfsm_act_if #(.N(N)) bus ();

  sfsm_act #(.N(N), .S(S), .LGS(LGS), .G(G), .INIT(INIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int st_m [N];
  logic [N-1:0] y_m, hi_m, lo_m;

  // model: clamp-arithmetic counter per channel, decode from the new value
  task automatic step(input logic r, input logic e, input logic m, input logic [N-1:0] xv,
                      input string tag);
    @(negedge clk);
    rst = r; bus.en = e; bus.mode = m; bus.x = xv;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (!r) begin
        st_m[i] = INIT; y_m[i] = 1'b0; hi_m[i] = 1'b0; lo_m[i] = 1'b0;
      end else if (e) begin
        st_m[i] = xv[i] ? ((st_m[i] + 1 > S-1) ? S-1 : st_m[i] + 1)
                        : ((st_m[i] - 1 < 0)   ? 0   : st_m[i] - 1);
        y_m[i]  = m ? (st_m[i] < S-G) : (st_m[i] >= S/2);
        hi_m[i] = (st_m[i] == S-1);
        lo_m[i] = (st_m[i] == 0);
      end
    end
    #1;
    total++;
    assert (bus.y === y_m) else begin
      bad++;
      $error("FAIL %s y: observed=%b expected=%b", tag, bus.y, y_m);
    end
`ifdef SFSM_ACT_SAT_EN
    total++;
    assert (bus.sat_hi === hi_m && bus.sat_lo === lo_m) else begin
      bad++;
      $error("FAIL %s sat: observed hi=%b lo=%b expected hi=%b lo=%b",
             tag, bus.sat_hi, bus.sat_lo, hi_m, lo_m);
    end
`endif
  endtask

  initial begin
    logic [N-1:0] xr;
    rst = 1'b0; bus.en = 1'b0; bus.mode = 1'b0; bus.x = '0;
    for (int i = 0; i < N; i++) st_m[i] = INIT;
    y_m = '0; hi_m = '0; lo_m = '0;

    step(1'b0, 1'b0, 1'b0, 4'b0000, "reset");
    step(1'b0, 1'b1, 1'b1, 4'b1111, "reset_en");

    // traffic, then reset mid-stream
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'($urandom), 4'($urandom), "pre_traffic");
    step(1'b0, 1'b1, 1'b0, 4'b1111, "reset_mid");

    // x[0] held high, x[1] held low: saturate both ends
    for (int k = 0; k < 20; k++) begin
      xr = 4'($urandom); xr[0] = 1'b1; xr[1] = 1'b0;
      step(1'b1, 1'b1, 1'b0, xr, "tanh_sat");
    end
    total++;
    assert (y_m[0] === 1'b1 && y_m[1] === 1'b0 && st_m[0] == 31 && st_m[1] == 0) else begin
      bad++;
      $error("FAIL tanh_sat_model: observed st0=%0d st1=%0d expected st0=31 st1=0", st_m[0], st_m[1]);
    end

    // exp threshold on lane 2
    step(1'b0, 1'b1, 1'b1, 4'b0000, "reset_exp");
    for (int k = 0; k < 16; k++) step(1'b1, 1'b1, 1'b1, 4'b0100, "exp_thresh");

    // enable low: everything frozen regardless of x and mode
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'($urandom), 4'($urandom), "en_hold");

    // lane 3 to 29 in tanh, then switch to exp at the 30 crossing
    step(1'b0, 1'b1, 1'b0, 4'b0000, "reset_sw");
    for (int k = 0; k < 13; k++) step(1'b1, 1'b1, 1'b0, 4'b1000, "climb");
    step(1'b1, 1'b1, 1'b1, 4'b1000, "mode_switch");
    total++;
    assert (bus.y[3] === 1'b0) else begin
      bad++;
      $error("FAIL mode_switch_y3: observed=%b expected=0", bus.y[3]);
    end

    // alternating input around the tanh midpoint
    step(1'b0, 1'b1, 1'b0, 4'b0000, "reset_alt");
    step(1'b1, 1'b1, 1'b0, 4'b0001, "alt");
    step(1'b1, 1'b1, 1'b0, 4'b0000, "alt");
    step(1'b1, 1'b1, 1'b0, 4'b0001, "alt");
    step(1'b1, 1'b1, 1'b0, 4'b0000, "alt");

    // random soak with occasional reset and enable drops
    for (int k = 0; k < 400; k++)
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 5) != 0),
           ($urandom_range(0, 9) == 0) ? ~bus.mode : bus.mode,
           4'($urandom), "random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
